// File: rtl/lane_deserializer_pkg.sv
// Shared types and constants for the three-lane serial-to-parallel deserializer.
package lane_deserializer_pkg;

    localparam int LANES  = 3;
    localparam int BYTE_W = 8;

    // Lane-enable encodings; 2'b11 behaves the same as 2'b10 (all three lanes).
    typedef enum logic [1:0] {
        MODE_A       = 2'b00,
        MODE_AB      = 2'b01,
        MODE_ABC     = 2'b10,
        MODE_ABC_ALT = 2'b11
    } mode_e;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Enabled-lane mask ordered {A,B,C}, so A lands in the MSB byte of the word.
    function automatic logic [LANES-1:0] mode_mask(input logic [1:0] m);
        case (m)
            MODE_A:  mode_mask = 3'b100;
            MODE_AB: mode_mask = 3'b110;
            default: mode_mask = 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/lane_deserializer_if.sv
// Frame, lane, FIFO-read and status signals of the lane deserializer.
interface lane_deserializer_if #(
    parameter int LVL_W = 3
);
    logic             VALID;
    logic             DIN_A;
    logic             DIN_B;
    logic             DIN_C;
    logic [1:0]       MODE;
    logic             RD_EN;
    logic             CLR_ERR;
    logic [23:0]      DATA_OUT;
    logic [2:0]       LANE_MASK;
    logic             EMPTY;
    logic             FULL;
    logic [LVL_W-1:0] LEVEL;
    logic             OVF;
    logic             FRAME_ERR;

    // Converter / consumer side.
    modport master (
        output VALID, DIN_A, DIN_B, DIN_C, MODE, RD_EN, CLR_ERR,
        input  DATA_OUT, LANE_MASK, EMPTY, FULL, LEVEL, OVF, FRAME_ERR
    );

    // Deserializer side.
    modport slave (
        input  VALID, DIN_A, DIN_B, DIN_C, MODE, RD_EN, CLR_ERR,
        output DATA_OUT, LANE_MASK, EMPTY, FULL, LEVEL, OVF, FRAME_ERR
    );
endinterface

// File: rtl/lane_deserializer_sync_fifo.sv
// First-word-fall-through FIFO with exact occupancy and a sticky overflow flag.
module sync_fifo #(
    parameter int WIDTH = 27,
    parameter int DEPTH = 4,
    parameter int LVL_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             clr_ovf_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [LVL_W-1:0] level_o,
    output logic             ovf_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, rd_q;
    logic [LVL_W-1:0] lvl_q;
    logic             ovf_q;
    logic             do_pop, do_push, ovf_set;

    // A pop on an empty FIFO is ignored; a pop while full frees the slot the push needs.
    always_comb begin
        empty_o = (lvl_q == '0);
        full_o  = (lvl_q == LVL_W'(DEPTH));
        do_pop  = pop_i && !empty_o;
        do_push = push_i && (!full_o || do_pop);
        ovf_set = push_i && full_o && !do_pop;
        dout_o  = empty_o ? '0 : mem_q[rd_q];
        level_o = lvl_q;
        ovf_o   = ovf_q;
    end

    // Storage needs no reset: the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

    // Pointers wrap naturally since DEPTH is a power of two; a set beats a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            lvl_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (do_push) wr_q <= wr_q + PTR_W'(1);
            if (do_pop)  rd_q <= rd_q + PTR_W'(1);
            lvl_q <= lvl_q + LVL_W'(do_push) - LVL_W'(do_pop);
            ovf_q <= ovf_set | (ovf_q & ~clr_ovf_i);
        end
    end

endmodule

// File: rtl/lane_deserializer.sv
// Collects MSB-first bytes from up to three serial lanes and queues 24-bit words.
module lane_deserializer
    import lane_deserializer_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int LVL_W      = 3
) (
    input  logic               CLK_48MHZ,
    input  logic               RSTN,
    lane_deserializer_if.slave bus
);
    localparam int WORD_W = LANES * BYTE_W + LANES;

    state_e                         state_q, state_d;
    logic [2:0]                     bitcnt_q, bitcnt_d;
    logic [LANES-1:0][BYTE_W-1:0]   sh_q, sh_d, sh_next, word_bytes;
    logic [1:0]                     bmode_q, bmode_d;
    logic                           ferr_q, ferr_d;
    logic [LANES-1:0]               din, word_mask;
    logic                           push;
    logic [WORD_W-1:0]              push_word, head;

    // Byte framing: all lanes shift every valid bit; disabled lanes are masked at push time.
    always_comb begin
        din       = {bus.DIN_A, bus.DIN_B, bus.DIN_C};
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        sh_d      = sh_q;
        bmode_d   = bmode_q;
        push      = 1'b0;
        ferr_d    = ferr_q & ~bus.CLR_ERR;
        word_mask = mode_mask(bmode_q);
        for (int l = 0; l < LANES; l++) begin
            sh_next[l]    = {sh_q[l][BYTE_W-2:0], din[l]};
            word_bytes[l] = sh_next[l] & {BYTE_W{word_mask[l]}};
        end
        push_word = {word_bytes, word_mask};
        case (state_q)
            IDLE: begin
                if (bus.VALID) begin
                    state_d  = SHIFT;
                    bitcnt_d = 3'd1;
                    bmode_d  = bus.MODE;
                    sh_d     = sh_next;
                end
            end
            default: begin
                if (bus.VALID) begin
                    sh_d     = sh_next;
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd0) bmode_d = bus.MODE;
                    if (bitcnt_q == 3'd7) push = 1'b1;
                end else begin
                    if (bitcnt_q != 3'd0) ferr_d = 1'b1;
                    bitcnt_d = 3'd0;
                    state_d  = IDLE;
                end
            end
        endcase
    end

    // Framing state register.
    always_ff @(posedge CLK_48MHZ) begin
        if (RSTN) begin
            state_q  <= IDLE;
            bitcnt_q <= '0;
            sh_q     <= '0;
            bmode_q  <= '0;
            ferr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            sh_q     <= sh_d;
            bmode_q  <= bmode_d;
            ferr_q   <= ferr_d;
        end
    end

    sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk       (CLK_48MHZ),
        .rst       (RSTN),
        .push_i    (push),
        .pop_i     (bus.RD_EN),
        .clr_ovf_i (bus.CLR_ERR),
        .din_i     (push_word),
        .dout_o    (head),
        .empty_o   (bus.EMPTY),
        .full_o    (bus.FULL),
        .level_o   (bus.LEVEL),
        .ovf_o     (bus.OVF)
    );

    assign bus.DATA_OUT  = head[WORD_W-1:LANES];
    assign bus.LANE_MASK = head[LANES-1:0];
    assign bus.FRAME_ERR = ferr_q;

endmodule

// File: doc/lane_deserializer.md
LANE_DESERIALIZER -- requirements
Module: lane_deserializer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, number of 24-bit word entries, power of two, minimum 2.
REQ-002 Parameter LVL_W, default 3, LEVEL width, equal to clog2(FIFO_DEPTH+1).
REQ-003 CLK_48MHZ  in  1  sole clock; all state updates on rising edge.
REQ-004 RSTN  in  1  synchronous, active-high reset; the name is kept per codebase convention.
REQ-005 VALID  in  1  frame-valid from the converter; lanes carry data bits while high.
REQ-006 DIN_A / DIN_B / DIN_C  in  1 each  serial lanes, MSB first.
REQ-007 MODE  in  2  lane enable: 00=A, 01=A+B, 10=A+B+C, 11=A+B+C.
REQ-008 RD_EN  in  1  pop request for the FIFO head.
REQ-009 CLR_ERR  in  1  clears the sticky error flags.
REQ-010 DATA_OUT  out  24  FIFO head, {A,B,C} bytes with A in bits 23:16.
REQ-011 LANE_MASK  out  3  enabled-lane mask of the head word, {A,B,C}.
REQ-012 EMPTY / FULL  out  1 each  FIFO status.
REQ-013 LEVEL  out  LVL_W  FIFO occupancy.
REQ-014 OVF / FRAME_ERR  out  1 each  sticky overflow and framing-error flags.

Function
REQ-015 FSM states are IDLE and SHIFT; a 3-bit counter BITCNT tracks bits received.
- IDLE with VALID=1 -> SHIFT.
- On that same edge: sample bit 7, BITCNT=1, latch MODE into a byte-mode register.
REQ-016 In SHIFT with VALID=1, each enabled lane shifts its bit into its byte LSB-side and BITCNT increments.
REQ-017 On the edge that samples the 8th bit (BITCNT=7, VALID=1):
- The word is assembled from the shift registers plus the current bit and pushed to the FIFO.
- BITCNT wraps to 0.
- FSM stays in SHIFT if VALID remains high at the next edge, otherwise returns to IDLE.
REQ-018 Disabled lanes contribute 0x00, and LANE_MASK records the latched byte-mode, not the live MODE.
REQ-019 A MODE change mid-byte has no effect until the next byte start.
REQ-020 VALID=0 in SHIFT with BITCNT 1..7: the partial byte is discarded, FRAME_ERR is set, BITCNT=0 and the FSM goes to IDLE.
REQ-021 VALID=0 at BITCNT=0 is a clean frame end and sets no error.
REQ-022 Latency: a pushed word is visible on DATA_OUT, and EMPTY=0, in the cycle after the 8th-bit edge.
REQ-023 The FIFO is first-word-fall-through, and DATA_OUT and LANE_MASK are 0 while EMPTY=1.
REQ-024 RD_EN while EMPTY is ignored and has no side effects.
REQ-025 Push while FULL without a pop drops the word and sets OVF; the FIFO contents are unchanged.
REQ-026 Push and pop on the same edge while FULL both occur, with no OVF and LEVEL unchanged.
REQ-027 Push and pop on the same edge while EMPTY: only the push occurs, and LEVEL becomes 1.
REQ-028 Read and write pointers wrap modulo FIFO_DEPTH.
REQ-029 LEVEL is exact at all times; FULL = (LEVEL==FIFO_DEPTH) and EMPTY = (LEVEL==0).
REQ-030 CLR_ERR=1 clears OVF and FRAME_ERR.
REQ-031 A set event on the same edge as CLR_ERR takes priority: the flag ends set.

Reset
REQ-032 While RSTN=1 at an edge the block is put in its reset state:
- FSM=IDLE, BITCNT=0, shift registers and byte-mode register = 0.
- Pointers and LEVEL = 0, EMPTY=1, FULL=0, OVF=0, FRAME_ERR=0, DATA_OUT=0, LANE_MASK=0.
REQ-033 Reset mid-byte or with a non-empty FIFO discards all data, sets no error flags, and overrides every other input.

Structure
REQ-034 A shared package holds:
- MODE encodings.
- The FSM state enum {IDLE, SHIFT}.
- Constants LANES=3 and BYTE_W=8.
REQ-035 One sub-module, sync_fifo, parameterised by width (27 = 24 data + 3 mask) and FIFO_DEPTH, owns pointers, LEVEL, FULL/EMPTY and OVF generation.

Verification
REQ-036 Bench covers: MODE=10, VALID high 8 cycles, A=0xA5, B=0x3C, C=0xFF -> next cycle DATA_OUT=0xA53CFF, LANE_MASK=111, LEVEL=1.
REQ-037 Bench covers: MODE=00, 16 VALID cycles, A=0x12 then 0x34 -> two entries 0x120000 and 0x340000, both LANE_MASK=100.
REQ-038 Bench covers: VALID drops after 5 bits -> no push, FRAME_ERR=1; a following full byte is captured correctly.
REQ-039 Bench covers: no reads, 5 bytes with FIFO_DEPTH=4 -> FULL=1, LEVEL=4, OVF=1, the first 4 words intact, the 5th lost.
REQ-040 Bench covers: FULL FIFO with RD_EN=1 on the 8th-bit edge -> OVF stays 0, LEVEL stays 4, head advances.
REQ-041 Bench covers: RSTN=1 at BITCNT=4 with LEVEL=2 -> next cycle EMPTY=1, LEVEL=0, flags 0; the next byte starts fresh.
